iob_axi_ram_responder: RTL
==========================

// Module: iob_axi_ram_responder
// PURPOSE
// AXI4 slave that answers the SoC's external-memory AXI master port from an on-chip RAM array.
// It is the responder end of the interface the SoC drives toward the DDR controller.
// Used in place of the DDR4 controller plus async bridge in simulation and on DDR-less FPGA builds.
// Single clock domain; the SoC and this block share clk_i.
// PARAMETERS
// AXI_ID_W    4   ID width for AW/AR/B/R
// AXI_ADDR_W  24  byte address width
// AXI_DATA_W  32  data width; 32, 64 or 128
// AXI_LEN_W   8   burst length field width
// MEM_ADDR_W  16  RAM depth in words = 2**MEM_ADDR_W
// PORTS
// clk_i        in   1  system clock
// rstn_i       in   1  synchronous, active-low reset
// axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}_i  in   AXI4 widths  write address; lock/cache/prot/qos ignored
// axi_awready_o                                               out  1            write address ready
// axi_w{data,strb,last,valid}_i                               in   AXI4 widths  write data
// axi_wready_o                                                out  1            write data ready
// axi_b{id,resp,valid}_o                                      out  ID/2/1       write response
// axi_bready_i                                                in   1            write response ready
// axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,valid}_i  in   AXI4 widths  read address; lock/cache/prot/qos ignored
// axi_arready_o                                               out  1            read address ready
// axi_r{id,data,resp,last,valid}_o                            out  ID/DATA/2/1/1  read data
// axi_rready_i                                                in   1            read data ready
// BEHAVIOUR
// - Reset: all *ready_o, *valid_o and rlast = 0; bid, bresp, rid, rdata, rresp = 0; FSM = IDLE; prio = WRITE.
// - RAM contents are not cleared by reset.
// - FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
// - One transaction at a time; no outstanding or interleaved bursts.
// - IDLE: awready_o/arready_o are combinational and are asserted only for the channel being granted.
//   - Grant with only one of awvalid/arvalid high: that channel.
//   - Grant with both high: the channel given by prio; prio then toggles (round-robin).
//   - On the AW handshake: latch id, addr, len and burst; go to WR_DATA.
//   - On the AR handshake: latch the same fields; go to RD_DATA.
// - WR_DATA: wready_o = 1.
//   - Each W handshake writes RAM[word_addr] using wstrb byte enables.
//   - After each beat: INCR (and WRAP, treated as INCR) adds 1 to word_addr; FIXED holds it.
//   - After len+1 beats go to WR_RESP. wlast is not used to end the burst.
//   - wlast low on the final beat, or high on an earlier beat, sets bresp = SLVERR (2'b10).
// - WR_RESP: bvalid_o = 1 with bid = awid; hold until bready_i; then go to IDLE.
//   - bvalid_o rises in the cycle after the last W handshake.
// - RD_DATA: synchronous RAM read.
//   - First rvalid_o comes 2 cycles after the AR handshake.
//   - The output register loads while (!rvalid_o || rready_i), giving 1 beat/cycle when rready_i is held high.
//   - rdata/rresp/rlast hold stable while rvalid_o && !rready_i.
//   - rid = arid on every beat; rlast = 1 on beat len.
//   - After the rlast handshake go to IDLE; no ready is granted in that same cycle.
// - awsize/arsize are ignored; every beat is a full AXI_DATA_W word.
// - word_addr = addr[MEM_ADDR_W+log2(AXI_DATA_W/8)-1 : log2(AXI_DATA_W/8)]; low byte-offset bits are ignored.
// - len = 0 means a single beat.
// - word_addr wraps modulo 2**MEM_ADDR_W inside a burst.
// - A reset in any state aborts the burst: return to IDLE, drop all valids; partial writes remain in RAM.
// CONFIGURATION
// - Macro IOB_AXI_RAM_RESPONDER_DECERR_EN enables range checking.
// - Defined: if any bits of addr above the RAM range are nonzero, the whole burst gets resp = DECERR (2'b11).
//   - Writes are suppressed and the W beats are still consumed.
//   - Reads return rdata = 0.
// - Undefined: the upper address bits are silently ignored (aliasing); resp = OKAY except for the wlast case.
// STRUCTURE
// - Shared package iob_axi_pkg: AXI_RESP_{OKAY,EXOKAY,SLVERR,DECERR}, AXI_BURST_{FIXED,INCR,WRAP}, FSM state encoding.
// - One sub-module: iob_ram_sp_be (single-port RAM, byte-enable write, registered read).
// - The FSM, address counter, beat counter and R output register stay in the top module.
// TESTING
// - Single write then read: AW addr=0x100 len=0 data=0xDEADBEEF strb=F -> bresp=0 bid=awid; AR 0x100 -> rdata=0xDEADBEEF, rlast=1.
// - INCR burst: write len=7 at 0x40 with data i; read len=7 with rready held high -> 8 beats in consecutive cycles, rlast on beat 7.
// - Backpressure: rready toggles 1/0 during len=3 read -> data stable when stalled, no beat lost or duplicated.
// - FIXED burst: write 4 beats to 0x80 with strb=1,2,4,8 and bytes 0x11,0x22,0x33,0x44 -> read returns 0x44332211.
// - Simultaneous awvalid+arvalid in IDLE twice -> first grants write, second grants read.
//   - Also: wlast missing on the last beat -> bresp=2'b10.
// - Reset asserted mid read burst -> rvalid=0 next cycle, FSM in IDLE, next AR served normally.
//   - With DECERR_EN: addr with bit MEM_ADDR_W+2 set -> resp=2'b11, RAM unchanged.

Source files
------------

// File: rtl/iob_axi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : iob_axi_pkg
// Description : AXI4 response/burst encodings and the RAM responder FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package iob_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_WR_RESP = 2'd2,
        ST_RD_DATA = 2'd3
    } axi_state_e;

endpackage
`default_nettype wire

// File: rtl/iob_axi_ram_responder_if.sv
`default_nettype none
// ============================================================================
// Interface   : iob_axi_ram_responder_if
// Description : AXI4 bus between the SoC memory master and the RAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface iob_axi_ram_responder_if #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8
) ();
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [AXI_LEN_W-1:0]    awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [AXI_ID_W-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [AXI_LEN_W-1:0]    arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic                    arvalid;
    logic                    arready;
    logic [AXI_ID_W-1:0]     rid;
    logic [AXI_DATA_W-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/iob_ram_sp_be.sv
`default_nettype none
// ============================================================================
// Module      : iob_ram_sp_be
// Description : Single-port RAM, per-byte write enables, registered read that
//               holds its output while en is low.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_ram_sp_be #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  wire logic                clk,
    input  wire logic                en,
    input  wire logic [DATA_W/8-1:0] we,
    input  wire logic [ADDR_W-1:0]   addr,
    input  wire logic [DATA_W-1:0]   wdata,
    output logic      [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (we[i]) begin
                    r_mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/iob_axi_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : iob_axi_ram_responder
// Description : AXI4 slave serving one burst at a time from on-chip RAM.
//               Define IOB_AXI_RAM_RESPONDER_DECERR_EN for out-of-range DECERR.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_axi_ram_responder
    import iob_axi_pkg::*;
#(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int MEM_ADDR_W = 16
) (
    input wire logic               clk_i,
    input wire logic               rstn_i,
    iob_axi_ram_responder_if.slave axi
);
    localparam int c_strb_w = AXI_DATA_W / 8;
    localparam int c_off    = $clog2(c_strb_w);

    axi_state_e             r_state;
    logic                   r_prio;
    logic [AXI_ID_W-1:0]    r_id;
    logic [AXI_LEN_W-1:0]   r_len;
    logic [1:0]             r_burst;
    logic [MEM_ADDR_W-1:0]  r_addr;
    logic [AXI_LEN_W-1:0]   r_beat;
    logic [AXI_LEN_W-1:0]   r_issue_cnt;
    logic                   r_issue_done;
    logic                   r_ram_vld;
    logic                   r_decerr;
    logic                   r_slverr;
    logic [AXI_ID_W-1:0]    r_bid;
    logic [1:0]             r_bresp;
    logic                   r_bvalid;
    logic [AXI_ID_W-1:0]    r_rid;
    logic [AXI_DATA_W-1:0]  r_rdata;
    logic [1:0]             r_rresp;
    logic                   r_rlast;
    logic                   r_rvalid;

    logic                   w_idle, w_aw_hs, w_ar_hs, w_w_hs, w_r_hs;
    logic                   w_w_last_beat, w_r_load, w_issue, w_step, w_oor;
    logic [AXI_ADDR_W-1:0]  w_hs_addr;
    logic [c_strb_w-1:0]    w_ram_we;
    logic [AXI_DATA_W-1:0]  w_ram_rdata;
    logic                   w_unused;

    assign w_idle      = (r_state == ST_IDLE);
    assign axi.awready = w_idle && axi.awvalid && (!axi.arvalid || !r_prio);
    assign axi.arready = w_idle && axi.arvalid && (!axi.awvalid ||  r_prio);
    assign axi.wready  = (r_state == ST_WR_DATA);
    assign w_aw_hs     = axi.awvalid && axi.awready;
    assign w_ar_hs     = axi.arvalid && axi.arready;
    assign w_w_hs      = axi.wvalid && axi.wready;
    assign w_r_hs      = r_rvalid && axi.rready;
    assign w_hs_addr   = w_aw_hs ? axi.awaddr : axi.araddr;
    assign w_w_last_beat = (r_beat == r_len);
    assign w_step      = (r_burst != AXI_BURST_FIXED);

`ifdef IOB_AXI_RAM_RESPONDER_DECERR_EN
    assign w_oor = ((w_hs_addr >> (MEM_ADDR_W + c_off)) != '0);
`else
    assign w_oor = 1'b0;
`endif

    // The RAM output register acts as a one-deep stage in front of the R register,
    // so a new read is issued only when that stage is empty or draining this cycle.
    assign w_r_load = !r_rvalid || axi.rready;
    assign w_issue  = (r_state == ST_RD_DATA) && !r_issue_done && (!r_ram_vld || w_r_load);
    assign w_ram_we = (w_w_hs && !r_decerr) ? axi.wstrb : '0;

    iob_ram_sp_be #(
        .ADDR_W (MEM_ADDR_W),
        .DATA_W (AXI_DATA_W)
    ) u_ram (
        .clk   (clk_i),
        .en    (w_w_hs || w_issue),
        .we    (w_ram_we),
        .addr  (r_addr),
        .wdata (axi.wdata),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state      <= ST_IDLE;
            r_prio       <= 1'b0;
            r_id         <= '0;
            r_len        <= '0;
            r_burst      <= AXI_BURST_INCR;
            r_addr       <= '0;
            r_beat       <= '0;
            r_issue_cnt  <= '0;
            r_issue_done <= 1'b0;
            r_ram_vld    <= 1'b0;
            r_decerr     <= 1'b0;
            r_slverr     <= 1'b0;
            r_bid        <= '0;
            r_bresp      <= AXI_RESP_OKAY;
            r_bvalid     <= 1'b0;
            r_rid        <= '0;
            r_rdata      <= '0;
            r_rresp      <= AXI_RESP_OKAY;
            r_rlast      <= 1'b0;
            r_rvalid     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (axi.awvalid && axi.arvalid) begin
                        r_prio <= ~r_prio;
                    end
                    if (w_aw_hs || w_ar_hs) begin
                        r_id         <= w_aw_hs ? axi.awid    : axi.arid;
                        r_len        <= w_aw_hs ? axi.awlen   : axi.arlen;
                        r_burst      <= w_aw_hs ? axi.awburst : axi.arburst;
                        r_addr       <= w_hs_addr[MEM_ADDR_W+c_off-1:c_off];
                        r_decerr     <= w_oor;
                        r_beat       <= '0;
                        r_slverr     <= 1'b0;
                        r_issue_cnt  <= '0;
                        r_issue_done <= 1'b0;
                        r_ram_vld    <= 1'b0;
                        r_state      <= w_aw_hs ? ST_WR_DATA : ST_RD_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (w_w_hs) begin
                        if (w_step) begin
                            r_addr <= r_addr + 1'b1;
                        end
                        r_beat <= r_beat + 1'b1;
                        if (w_w_last_beat != axi.wlast) begin
                            r_slverr <= 1'b1;
                        end
                        if (w_w_last_beat) begin
                            r_state  <= ST_WR_RESP;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_id;
                            if (r_decerr) begin
                                r_bresp <= AXI_RESP_DECERR;
                            end else if (r_slverr || !axi.wlast) begin
                                r_bresp <= AXI_RESP_SLVERR;
                            end else begin
                                r_bresp <= AXI_RESP_OKAY;
                            end
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (axi.bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RD_DATA: begin
                    if (w_issue) begin
                        if (w_step) begin
                            r_addr <= r_addr + 1'b1;
                        end
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                        if (r_issue_cnt == r_len) begin
                            r_issue_done <= 1'b1;
                        end
                        r_ram_vld <= 1'b1;
                    end else if (w_r_load) begin
                        r_ram_vld <= 1'b0;
                    end
                    if (w_r_load) begin
                        if (r_ram_vld) begin
                            r_rvalid <= 1'b1;
                            r_rid    <= r_id;
                            r_rdata  <= r_decerr ? '0 : w_ram_rdata;
                            r_rresp  <= r_decerr ? AXI_RESP_DECERR : AXI_RESP_OKAY;
                            r_rlast  <= (r_beat == r_len);
                            r_beat   <= r_beat + 1'b1;
                        end else begin
                            r_rvalid <= 1'b0;
                        end
                    end
                    if (w_r_hs && r_rlast) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign axi.bid    = r_bid;
    assign axi.bresp  = r_bresp;
    assign axi.bvalid = r_bvalid;
    assign axi.rid    = r_rid;
    assign axi.rdata  = r_rdata;
    assign axi.rresp  = r_rresp;
    assign axi.rlast  = r_rlast;
    assign axi.rvalid = r_rvalid;

    assign w_unused = ^{axi.awsize, axi.awlock, axi.awcache, axi.awprot, axi.awqos,
                        axi.arsize, axi.arlock, axi.arcache, axi.arprot, axi.arqos,
                        axi.awaddr, axi.araddr, w_hs_addr};
endmodule
`default_nettype wire
